// File: rtl/mystic_csr_pkg.sv
// Shared definitions for the CSR controller: op encodings, FSM states, defaults.
package mystic_csr_pkg;

  localparam int RD_LAT_DEF       = 4;
  localparam int CLEAR_CYCLES_DEF = 4096;

  // Instruction op encodings; 101-111 are reserved and treated as READ.
  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_RW    = 3'b001;
  localparam logic [2:0] OP_RS    = 3'b010;
  localparam logic [2:0] OP_RC    = 3'b011;
  localparam logic [2:0] OP_WONLY = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RWAIT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/mystic_csr_alu.sv
// Read-modify-write datapath: new CSR value and whether it must be written back.
module mystic_csr_alu
  import mystic_csr_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [63:0] old_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] new_o,
  output logic        we_o
);

  // Set/clear with a zero mask leave the CSR untouched, so they skip the write.
  always_comb begin
    new_o = old_i;
    we_o  = 1'b0;
    case (op_i)
      OP_RW: begin
        new_o = wdata_i;
        we_o  = 1'b1;
      end
      OP_RS: begin
        new_o = old_i | wdata_i;
        we_o  = |wdata_i;
      end
      OP_RC: begin
        new_o = old_i & ~wdata_i;
        we_o  = |wdata_i;
      end
      OP_WONLY: begin
        new_o = wdata_i;
        we_o  = 1'b1;
      end
      default: begin
        new_o = old_i;
        we_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mystic_csr_ctrl.sv
// CSR access controller: clears the store after reset, then serialises trap
// writes and CSR instructions (read / RMW / write-only) onto a single store port.
//
// Handshake: a request is accepted on a rising edge where valid and ready are
// both high; ready never depends on the same-channel valid. Both readies are
// high only in IDLE, and the instruction channel is held off while a trap
// request is present, so a trap always wins a simultaneous request.
module mystic_csr_ctrl
  import mystic_csr_pkg::*;
#(
  parameter int RD_LAT       = RD_LAT_DEF,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [2:0]  instr_op_i,
  input  logic [11:0] instr_addr_i,
  input  logic [63:0] instr_wdata_i,
  output logic [63:0] instr_rdata_o,
  output logic        instr_done_o,
  input  logic        trap_valid_i,
  output logic        trap_ready_o,
  input  logic [11:0] trap_addr_i,
  input  logic [63:0] trap_wdata_i,
  output logic        trap_done_o,
  output logic        csr_disable_n_o,
  output logic        csr_we_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_din_o,
  input  logic [63:0] csr_dout_i,
  output logic        init_done_o,
  output logic        busy_o,
  output state_e      state_o
);

  localparam int CNT_MAX = (CLEAR_CYCLES > RD_LAT) ? CLEAR_CYCLES : RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              is_trap_q, is_trap_d;
  logic [2:0]        op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       din_q, din_d;
  logic [63:0]       old_q, old_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [63:0]       alu_new;
  logic              alu_we;

  mystic_csr_alu u_alu (
    .op_i    (op_q),
    .old_i   (csr_dout_i),
    .wdata_i (wdata_q),
    .new_o   (alu_new),
    .we_o    (alu_we)
  );

  // Next-state and datapath updates; the counter is shared by the clear and the read wait.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    is_trap_d   = is_trap_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    din_d       = din_q;
    old_d       = old_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CLEAR_LAST) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (trap_valid_i) begin
          is_trap_d = 1'b1;
          addr_d    = trap_addr_i;
          din_d     = trap_wdata_i;
          state_d   = ST_WRITE;
        end else if (instr_valid_i) begin
          is_trap_d = 1'b0;
          op_d      = instr_op_i;
          addr_d    = instr_addr_i;
          wdata_d   = instr_wdata_i;
          old_d     = '0;
          cnt_d     = '0;
          if (instr_op_i == OP_WONLY) begin
            din_d   = instr_wdata_i;
            state_d = ST_WRITE;
          end else begin
            state_d = (RD_LAT == 0) ? ST_CAPTURE : ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        old_d = csr_dout_i;
        din_d = alu_new;
        if (alu_we) begin
          state_d = ST_WRITE;
        end else begin
          rdata_d = csr_dout_i;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (!is_trap_q) rdata_d = old_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      is_trap_q   <= 1'b0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      din_q       <= '0;
      old_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      is_trap_q   <= is_trap_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      din_q       <= din_d;
      old_q       <= old_d;
      rdata_q     <= rdata_d;
    end
  end

  assign instr_ready_o   = (state_q == ST_IDLE) && !trap_valid_i;
  assign trap_ready_o    = (state_q == ST_IDLE);
  assign instr_done_o    = (state_q == ST_RESP) && !is_trap_q;
  assign trap_done_o     = (state_q == ST_RESP) && is_trap_q;
  assign instr_rdata_o   = rdata_q;
  assign csr_disable_n_o = (state_q != ST_INIT);
  assign csr_we_o        = (state_q == ST_WRITE);
  assign csr_addr_o      = addr_q;
  assign csr_din_o       = din_q;
  assign init_done_o     = init_done_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign state_o         = state_q;

endmodule
